// File: rtl/ones_count_frame_loader.sv
// Serial-to-parallel frame loader and result sampler for a 127-bit ones counter.
// Holds the frame on the counter input and samples the count after a fixed settle time.
module ones_count_frame_loader #(
    parameter int WIDTH  = 127,
    parameter int CNT_W  = 7,
    parameter int SETTLE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] vec_out,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             mismatch,
    output logic             busy
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [7:0] TIMER_INIT = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] running;
    logic [7:0]       timer;
    logic             accept;
    logic             last_bit;

    assign bit_ready = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_LOAD);
    assign accept    = bit_valid && bit_ready;
    assign last_bit  = (idx == IDX_W'(WIDTH - 1));

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:   if (accept && last_bit)           state_d = ST_SETTLE;
            ST_SETTLE: if (timer == 8'd0)                state_d = ST_HOLD;
            ST_HOLD:   if (count_valid && count_ready)   state_d = ST_LOAD;
            default:                                     state_d = ST_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // The frame is a plain register, not a memory, so it is cleared on reset/abort
    // to keep unwritten counter inputs at zero.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            idx         <= '0;
            running     <= '0;
            timer       <= '0;
            vec_out     <= '0;
            count_out   <= '0;
            count_valid <= 1'b0;
            mismatch    <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        vec_out[idx] <= bit_in;
                        running      <= running + {{(CNT_W-1){1'b0}}, bit_in};
                        if (last_bit) begin
                            idx   <= '0;
                            timer <= TIMER_INIT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (timer == 8'd0) begin
                        count_out   <= cnt_in;
                        mismatch    <= (cnt_in != running);
                        count_valid <= 1'b1;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                ST_HOLD: begin
                    // count_out is left as-is; only the valid/flag and frame are retired.
                    if (count_valid && count_ready) begin
                        count_valid <= 1'b0;
                        mismatch    <= 1'b0;
                        vec_out     <= '0;
                        running     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ones_count_frame_loader.sv
// Self-checking bench for ones_count_frame_loader with a behavioural ones counter
// and a scoreboard of expected results.
module tb_ones_count_frame_loader;
    localparam int WIDTH  = 127;
    localparam int CNT_W  = 7;
    localparam int SETTLE = 8;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic             mm;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic [WIDTH-1:0] vec_out;
    logic [CNT_W-1:0] cnt_in;
    logic [CNT_W-1:0] count_out;
    logic             count_valid;
    logic             count_ready;
    logic             mismatch;
    logic             busy;

    logic             force_cnt;
    logic [CNT_W-1:0] force_val;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the combinational ones counter.
    assign cnt_in = force_cnt ? force_val : CNT_W'($countones(vec_out));

    ones_count_frame_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .vec_out    (vec_out),
        .cnt_in     (cnt_in),
        .count_out  (count_out),
        .count_valid(count_valid),
        .count_ready(count_ready),
        .mismatch   (mismatch),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] actual,
                         input logic [WIDTH-1:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the first nbits of frame, idling `gap` cycles before each bit.
    task automatic send_bits(input logic [WIDTH-1:0] frame, input int nbits, input int gap);
        for (int i = 0; i < nbits; i++) begin
            int waited;
            waited = 0;
            for (int g = 0; g < gap; g++) begin
                bit_valid = 1'b0;
                tick();
            end
            bit_valid = 1'b1;
            bit_in    = frame[i];
            while (!bit_ready && waited < 300) begin
                tick();
                waited++;
            end
            if (waited >= 300) check("bit_ready_timeout", 0, 1);
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!count_valid && n < 100) begin
            tick();
            n++;
        end
        if (!count_valid) check({tag, "_valid_timeout"}, 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vec_out"},     vec_out,     '0);
        check({tag, "_count_out"},   count_out,   0);
        check({tag, "_count_valid"}, count_valid, 0);
        check({tag, "_mismatch"},    mismatch,    0);
        check({tag, "_busy"},        busy,        0);
        check({tag, "_bit_ready"},   bit_ready,   1);
    endtask

    // Scoreboard consumer: compares at every handshake.
    always @(negedge clk) begin
        if (rst_n && !clear && count_valid && count_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_count_out", count_out, mon_e.count);
                check("sb_mismatch",  mismatch,  mon_e.mm);
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] frame;
        int               e_cyc;
        bit               hold_ok;
        logic [CNT_W-1:0] held;
        int               n;

        rst_n = 1'b0; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        count_ready = 1'b1; force_cnt = 1'b0; force_val = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // All ones, downstream always ready: exact latency and one-cycle pulse.
        frame = '1;
        sb_q.push_back('{count: 7'd127, mm: 1'b0});
        send_bits(frame, WIDTH, 0);
        e_cyc = cyc;
        wait_valid("ones");
        check("ones_latency", cyc - e_cyc, SETTLE);
        tick();
        check("ones_pulse", count_valid, 0);
        check("ones_bit_ready_after", bit_ready, 1);

        // Alternating bits with downstream stalled for 20 cycles.
        for (int i = 0; i < WIDTH; i++) frame[i] = (i % 2 == 0);
        count_ready = 1'b0;
        sb_q.push_back('{count: 7'd64, mm: 1'b0});
        send_bits(frame, WIDTH, 0);
        wait_valid("alt");
        held    = count_out;
        hold_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!count_valid || count_out !== held || bit_ready || vec_out !== frame) hold_ok = 1'b0;
            tick();
        end
        check("alt_hold_stable", hold_ok, 1);
        check("alt_held_count", held, 64);
        check("alt_vec0",   vec_out[0],   1);
        check("alt_vec1",   vec_out[1],   0);
        check("alt_vec126", vec_out[126], 1);
        count_ready = 1'b1;
        tick();
        check("alt_bit_ready_after", bit_ready, 1);

        // Gapped valid, ones only at 0, 63 and 126.
        frame = '0;
        frame[0] = 1'b1; frame[63] = 1'b1; frame[126] = 1'b1;
        sb_q.push_back('{count: 7'd3, mm: 1'b0});
        send_bits(frame, WIDTH, 2);
        tick();
        check("gap_busy", busy, 1);
        check("gap_vec_settle", vec_out, frame);
        check("gap_no_valid_yet", count_valid, 0);
        wait_valid("gap");
        tick();

        // Counter output forced to 5 against a frame of ten ones.
        frame = '0;
        frame[9:0] = '1;
        force_cnt = 1'b1; force_val = 7'd5;
        count_ready = 1'b0;
        sb_q.push_back('{count: 7'd5, mm: 1'b1});
        send_bits(frame, WIDTH, 0);
        wait_valid("force");
        check("force_mismatch", mismatch, 1);
        check("force_count", count_out, 5);
        count_ready = 1'b1;
        tick();
        check("force_mismatch_clear", mismatch, 0);
        check("force_valid_clear", count_valid, 0);
        force_cnt = 1'b0;

        // Abort after 50 ones, then an all-zero frame.
        frame = '1;
        send_bits(frame, 50, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_vec_out", vec_out, '0);
        check("clear_bit_ready", bit_ready, 1);
        check("clear_busy", busy, 0);
        frame = '0;
        sb_q.push_back('{count: 7'd0, mm: 1'b0});
        send_bits(frame, WIDTH, 0);
        wait_valid("zeros");
        tick();

        // Reset during SETTLE.
        for (int i = 0; i < WIDTH; i++) frame[i] = 1'($urandom_range(0, 1));
        send_bits(frame, WIDTH, 0);
        tick();
        tick();
        check("settle_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("rst_settle");
        rst_n = 1'b1;

        // Reset during HOLD.
        count_ready = 1'b0;
        send_bits(frame, WIDTH, 0);
        wait_valid("hold_pre_rst");
        rst_n = 1'b0;
        tick();
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        count_ready = 1'b1;

        // Following frame counts correctly.
        for (int i = 0; i < WIDTH; i++) frame[i] = 1'($urandom_range(0, 1));
        sb_q.push_back('{count: CNT_W'($countones(frame)), mm: 1'b0});
        send_bits(frame, WIDTH, 0);
        wait_valid("post_rst");
        tick();

        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ones_count_frame_loader.md
Name: ones_count_frame_loader

Overview:
- Upstream feeder and result sampler for the 127-bit combinational ones counter.
- Assembles a bit-serial frame into a 127-bit parallel vector and holds it stable on the counter's input.
- Waits a fixed settle time to cover the counter's adder-tree propagation delay, then samples the 7-bit count and offers it downstream on a valid/ready handshake.
- Keeps an internal running ones count and flags any disagreement with the sampled count (self-check).

Parameters:
- WIDTH, 127, frame length in bits; equals the counter input width.
- CNT_W, 7, count width; must satisfy 2**CNT_W > WIDTH.
- SETTLE, 8, cycles between last-bit acceptance and count sampling; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- clear  input  1  synchronous abort; drops any partial frame or pending result.
- bit_in  input  1  serial data bit; frame bit 0 first.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  loader accepts a bit this cycle.
- vec_out  output  WIDTH  assembled frame; drives the counter input A.
- cnt_in  input  CNT_W  counter output N.
- count_out  output  CNT_W  sampled ones count.
- count_valid  output  1  count_out is valid.
- count_ready  input  1  downstream accepts count_out.
- mismatch  output  1  sampled count differs from internal running count; qualified by count_valid.
- busy  output  1  high in SETTLE and HOLD.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=LOAD, idx=0, running=0.
  - vec_out=0, count_out=0, count_valid=0, mismatch=0, busy=0.
  - bit_ready=1 from the first cycle after reset.
- Priority: rst_n, then clear, then normal operation.
- clear=1 at an edge, from any state:
  - Same register effect as reset.
  - A pending count is discarded without a handshake.
- State LOAD:
  - bit_ready=1.
  - Accept = bit_valid and bit_ready.
  - On accept:
    - vec_out[idx] <= bit_in.
    - running <= running + bit_in.
    - idx <= idx+1.
  - On accept with idx==WIDTH-1: state <= SETTLE, timer <= SETTLE-1, idx <= 0.
- State SETTLE:
  - bit_ready=0; vec_out frozen.
  - If timer==0 at an edge:
    - count_out <= cnt_in.
    - mismatch <= (cnt_in != running).
    - count_valid <= 1.
    - state <= HOLD.
  - Otherwise timer decrements.
  - count_valid therefore rises exactly SETTLE edges after the edge that accepted the last bit.
- State HOLD:
  - bit_ready=0.
  - count_out, mismatch and vec_out are stable while count_valid=1 and count_ready=0.
  - On count_valid and count_ready at an edge:
    - count_valid <= 0, mismatch <= 0.
    - vec_out <= 0, running <= 0.
    - state <= LOAD.
- count_ready high in any state other than HOLD has no effect.
- bit_valid while bit_ready=0 has no effect; the bit is neither consumed nor queued.
- Unwritten bits of vec_out stay 0 during LOAD. The counter may produce partial counts during LOAD; they are never sampled.
- Widths:
  - running is CNT_W bits and cannot overflow because WIDTH < 2**CNT_W.
  - idx is ceil(log2(WIDTH)) bits.
  - timer is 8 bits.
- Back-to-back frames: first bit of the next frame is accepted no earlier than the edge after the HOLD handshake. Throughput is WIDTH + SETTLE + 1 cycles per frame at best.

Test Plan:
- Reset then 127 ones at bit_valid=1, count_ready=1, SETTLE=8, counter connected:
  - count_valid pulses for 1 cycle, 8 edges after the 127th accept.
  - count_out=127, mismatch=0.
  - bit_ready back to 1 on the next cycle.
- Frame with alternating bits starting with 1 (64 ones), count_ready held 0 for 20 cycles:
  - count_out=64 with count_valid held stable throughout.
  - bit_ready=0 until the handshake.
  - vec_out[0]=1, vec_out[1]=0, vec_out[126]=1.
- Gapped bit_valid (valid every third cycle), frame with ones only at indices 0, 63 and 126:
  - count_out=3.
  - vec_out has exactly bits 0, 63 and 126 set during SETTLE.
- cnt_in forced to a constant 5 with a frame of 10 ones:
  - count_out=5, mismatch=1 with count_valid.
  - mismatch clears at the handshake.
- clear after 50 accepted bits, then a full 127-bit frame of all zeros:
  - count_out=0; no result is produced for the aborted frame.
  - vec_out=0 the cycle after clear.
- rst_n low during SETTLE and again during HOLD:
  - All outputs return to reset values on the next edge.
  - bit_ready=1 after release; the following frame counts correctly.
